// File: rtl/cache_pkg.sv
// Shared types for the associative cache set.
//   mode_e        : access mode encoding on the 'mode' port
//   flush_state_e : write-back walk state
//   LfuCntWidth   : width of the per-way use counter (LFU build only)
package cache_pkg;

  typedef enum logic [1:0] {
    ModeReq   = 2'b00,
    ModeAlloc = 2'b01,
    ModeRead  = 2'b10,
    ModeWrite = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StScan  = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } flush_state_e;

  localparam int unsigned LfuCntWidth = 8;

endpackage

// File: rtl/cache_way.sv
// One way of the set: tag, valid, dirty, replacement state and the line words.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   rd_index_i/rd_word_o: combinational word read port
//   wr_en_i/wr_index_i/wr_data_i : word write (also marks the line dirty)
//   alloc_en_i/alloc_tag_i       : install a new tag (valid, clean)
//   clean_en_i          : clear dirty after write-back
//   rep_en_i/rep_d_i    : load new replacement state (age or use counter)
//   valid_o/dirty_o/tag_o/rep_o  : current way state
// Line words are deliberately not reset.
module cache_way #(
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned LINE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REP_WIDTH  = 2,
  parameter logic [REP_WIDTH-1:0] REP_INIT = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LINE_WIDTH-1:0] rd_index_i,
  output logic [DATA_WIDTH-1:0] rd_word_o,
  input  logic                  wr_en_i,
  input  logic [LINE_WIDTH-1:0] wr_index_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  alloc_en_i,
  input  logic [TAG_WIDTH-1:0]  alloc_tag_i,
  input  logic                  clean_en_i,
  input  logic                  rep_en_i,
  input  logic [REP_WIDTH-1:0]  rep_d_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic [REP_WIDTH-1:0]  rep_o
);

  localparam int unsigned Words = 2 ** LINE_WIDTH;

  logic [DATA_WIDTH-1:0] words_q [Words];
  logic                  valid_q, valid_d;
  logic                  dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    rep_d   = rep_q;
    if (alloc_en_i) begin
      valid_d = 1'b1;
      dirty_d = 1'b0;
      tag_d   = alloc_tag_i;
    end else if (wr_en_i) begin
      dirty_d = 1'b1;
    end else if (clean_en_i) begin
      dirty_d = 1'b0;
    end
    if (rep_en_i) begin
      rep_d = rep_d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      rep_q   <= REP_INIT;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      rep_q   <= rep_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      words_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_word_o = words_q[rd_index_i];
  assign valid_o   = valid_q;
  assign dirty_o   = dirty_q;
  assign tag_o     = tag_q;
  assign rep_o     = rep_q;

endmodule

// File: rtl/assoc_cache_set.sv
// One set of an N-way associative cache with LRU replacement and a
// write-back flush walker.
// Ports:
//   clk, reset (async, active-high), en (global enable), tick_en (replacement update)
//   mode/target/index/data : access request (10 read, 11 write, 00 req, 01 alloc)
//   hit/out                : combinational lookup result
//   dirty/tag/victim       : state of the way chosen for replacement
//   flush_req/flush_busy/flush_done : write-back walk control
//   wb_valid/wb_ready/wb_tag/wb_index/wb_data : write-back beat handshake
// Build option: define CACHE_LFU_EN to replace LRU ages with 8-bit saturating
// use counters (victim = invalid way first, else lowest count, lowest index on ties).
`ifndef CACHE_T
`define CACHE_T 8
`endif
`ifndef CACHE_B
`define CACHE_B 2
`endif
`ifndef CACHE_E
`define CACHE_E 4
`endif

module assoc_cache_set
  import cache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = `CACHE_T,
  parameter int unsigned LINE_WIDTH = `CACHE_B,
  parameter int unsigned SET_SIZE   = `CACHE_E,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEY_WIDTH  = $clog2(SET_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  tick_en,
  input  logic [1:0]            mode,
  input  logic [TAG_WIDTH-1:0]  target,
  input  logic [LINE_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  dirty,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [KEY_WIDTH-1:0]  victim,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic [LINE_WIDTH-1:0] wb_index,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  flush_done
);

`ifdef CACHE_LFU_EN
  localparam int unsigned RepWidth = LfuCntWidth;
`else
  localparam int unsigned RepWidth = KEY_WIDTH;
`endif

  logic [SET_SIZE-1:0]   way_valid, way_dirty, match;
  logic [SET_SIZE-1:0]   wr_en, alloc_en, clean_en, rep_en;
  logic [TAG_WIDTH-1:0]  way_tag  [SET_SIZE];
  logic [DATA_WIDTH-1:0] way_word [SET_SIZE];
  logic [RepWidth-1:0]   way_rep  [SET_SIZE];
  logic [RepWidth-1:0]   rep_d    [SET_SIZE];

  flush_state_e          state_q, state_d;
  logic [KEY_WIDTH:0]    way_ptr_q, way_ptr_d;  // extra bit marks "past the last way"
  logic [LINE_WIDTH-1:0] word_ptr_q, word_ptr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  flush_done_q, flush_done_d;

  mode_e                 mode_op;
  logic                  busy, access, touch;
  logic                  read_op, write_op, alloc_op;
  logic [KEY_WIDTH-1:0]  hit_way, victim_way, touch_way, ptr_way;
  logic [LINE_WIDTH-1:0] rd_index;

  assign mode_op  = mode_e'(mode);
  assign busy     = (state_q != StIdle);
  assign access   = en && !busy;
  assign read_op  = (mode_op == ModeRead);
  assign write_op = (mode_op == ModeWrite);
  assign alloc_op = (mode_op == ModeAlloc);
  assign ptr_way  = way_ptr_q[KEY_WIDTH-1:0];
  // While walking, the shared read port serves the write-back beat.
  assign rd_index = busy ? word_ptr_q : index;

  for (genvar g = 0; g < SET_SIZE; g++) begin : g_way
`ifdef CACHE_LFU_EN
    localparam logic [RepWidth-1:0] RepInit = '0;
`else
    localparam logic [RepWidth-1:0] RepInit = RepWidth'(g);
`endif
    cache_way #(
      .TAG_WIDTH  (TAG_WIDTH),
      .LINE_WIDTH (LINE_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .REP_WIDTH  (RepWidth),
      .REP_INIT   (RepInit)
    ) u_way (
      .clk_i       (clk),
      .rst_i       (reset),
      .rd_index_i  (rd_index),
      .rd_word_o   (way_word[g]),
      .wr_en_i     (wr_en[g]),
      .wr_index_i  (index),
      .wr_data_i   (data),
      .alloc_en_i  (alloc_en[g]),
      .alloc_tag_i (target),
      .clean_en_i  (clean_en[g]),
      .rep_en_i    (rep_en[g]),
      .rep_d_i     (rep_d[g]),
      .valid_o     (way_valid[g]),
      .dirty_o     (way_dirty[g]),
      .tag_o       (way_tag[g]),
      .rep_o       (way_rep[g])
    );
  end

  // Lookup: at most one way can match, so a simple priority encode suffices.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int i = 0; i < SET_SIZE; i++) begin
      match[i] = way_valid[i] && (way_tag[i] == target);
      if (match[i]) hit_way = KEY_WIDTH'(i);
    end
  end

  assign hit = (|match) && !busy;
  assign out = hit ? way_word[hit_way] : '0;

  // Victim selection: lowest-index invalid way first.
  always_comb begin
    logic                found;
    logic [RepWidth-1:0] best;
    found      = 1'b0;
    victim_way = '0;
    best       = '1;
    for (int i = 0; i < SET_SIZE; i++) begin
      if (!found && !way_valid[i]) begin
        victim_way = KEY_WIDTH'(i);
        found      = 1'b1;
      end
    end
    if (!found) begin
`ifdef CACHE_LFU_EN
      victim_way = '0;
      best       = way_rep[0];
      for (int i = 1; i < SET_SIZE; i++) begin
        if (way_rep[i] < best) begin
          best       = way_rep[i];
          victim_way = KEY_WIDTH'(i);
        end
      end
`else
      for (int i = 0; i < SET_SIZE; i++) begin
        if (way_rep[i] == RepWidth'(SET_SIZE - 1)) victim_way = KEY_WIDTH'(i);
      end
`endif
    end
  end

  assign victim = victim_way;
  assign dirty  = way_dirty[victim_way];
  assign tag    = way_tag[victim_way];

  // Access side effects and replacement-state update.
  always_comb begin
    touch_way = alloc_op ? victim_way : hit_way;
    touch     = access && (alloc_op || (tick_en && hit && (read_op || write_op)));
    wr_en     = '0;
    alloc_en  = '0;
    rep_en    = '0;
    for (int i = 0; i < SET_SIZE; i++) begin
      rep_d[i]    = way_rep[i];
      wr_en[i]    = access && write_op && match[i];
      alloc_en[i] = access && alloc_op && (victim_way == KEY_WIDTH'(i));
`ifdef CACHE_LFU_EN
      if (touch && (touch_way == KEY_WIDTH'(i))) begin
        rep_en[i] = 1'b1;
        if (alloc_op)              rep_d[i] = RepWidth'(1);
        else if (way_rep[i] != '1) rep_d[i] = way_rep[i] + RepWidth'(1);
      end
`else
      // Ages stay a permutation: younger-than-touched ways age by one.
      rep_en[i] = touch;
      if (touch_way == KEY_WIDTH'(i))           rep_d[i] = '0;
      else if (way_rep[i] < way_rep[touch_way]) rep_d[i] = way_rep[i] + RepWidth'(1);
`endif
    end
  end

  // Flush walker next state.
  always_comb begin
    state_d    = state_q;
    way_ptr_d  = way_ptr_q;
    word_ptr_d = word_ptr_q;
    clean_en   = '0;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (flush_req) begin
            state_d   = StScan;
            way_ptr_d = '0;
          end
        end
        StScan: begin
          if (way_ptr_q == (KEY_WIDTH + 1)'(SET_SIZE)) begin
            state_d = StDone;
          end else if (way_valid[ptr_way] && way_dirty[ptr_way]) begin
            state_d    = StDrain;
            word_ptr_d = '0;
          end else begin
            way_ptr_d = way_ptr_q + 1'b1;
          end
        end
        StDrain: begin
          if (wb_ready) begin
            if (word_ptr_q == '1) begin
              clean_en[ptr_way] = 1'b1;
              way_ptr_d         = way_ptr_q + 1'b1;
              state_d           = StScan;
            end else begin
              word_ptr_d = word_ptr_q + 1'b1;
            end
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    wb_valid_d   = (state_d == StDrain);
    flush_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      way_ptr_q    <= '0;
      word_ptr_q   <= '0;
      wb_valid_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      way_ptr_q    <= way_ptr_d;
      word_ptr_q   <= word_ptr_d;
      wb_valid_q   <= wb_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign flush_busy = busy;
  assign wb_valid   = wb_valid_q;
  assign flush_done = flush_done_q;
  assign wb_tag     = way_tag[ptr_way];
  assign wb_index   = word_ptr_q;
  assign wb_data    = way_word[ptr_way];

endmodule

// File: doc/assoc_cache_set.md
ASSOC_CACHE_SET -- requirements
Module: assoc_cache_set

Interface
REQ-001 Parameter TAG_WIDTH, default `CACHE_T, tag bits.
REQ-002 Parameter LINE_WIDTH, default `CACHE_B, word-offset bits; a line holds 2**LINE_WIDTH words.
REQ-003 Parameter SET_SIZE, default `CACHE_E, ways (power of two, >=2).
REQ-004 Parameter DATA_WIDTH, default 32, word bits.
REQ-005 Derived parameter KEY_WIDTH, default $clog2(SET_SIZE), way-index bits.
REQ-006 Port clk  in  1  sole clock, rising edge.
REQ-007 Port reset  in  1  asynchronous, active-high reset.
REQ-008 Port en  in  1  global enable; no state changes when 0.
REQ-009 Port tick_en  in  1  permits replacement-state update.
REQ-010 Port mode  in  2  10 read, 11 write, 00 req, 01 alloc.
REQ-011 Ports target/index/data  in  TAG_WIDTH/LINE_WIDTH/DATA_WIDTH  lookup tag, word offset, write data.
REQ-012 Ports hit/out  out  1/DATA_WIDTH  lookup hit, read word.
REQ-013 Ports dirty/tag/victim  out  1/TAG_WIDTH/KEY_WIDTH  victim dirtiness, victim tag, victim way.
REQ-014 Port flush_req  in  1  start a write-back walk.
REQ-015 Port flush_busy  out  1  walk in progress.
REQ-016 Ports wb_valid/wb_ready  out/in  1/1  write-back handshake.
REQ-017 Ports wb_tag/wb_index/wb_data  out  TAG_WIDTH/LINE_WIDTH/DATA_WIDTH  write-back beat.
REQ-018 Port flush_done  out  1  one-cycle pulse at walk end.

Function
REQ-019 hit SHALL be combinational: some way valid with tag == target; at most one way matches.
REQ-020 out SHALL be the hit way's word[index], else 0.
REQ-021 Read SHALL change no data; on hit with en&tick_en the hit way becomes MRU at the clock edge.
REQ-022 Write hit with en SHALL store data into word[index], set dirty, and, with tick_en, make the way MRU; write miss SHALL change nothing.
REQ-023 Victim SHALL be the lowest-index invalid way, else the way with age SET_SIZE-1; dirty/tag SHALL show that way's state in every mode.
REQ-024 Alloc with en SHALL set victim tag=target, valid=1, dirty=0, age=0 (MRU); data words are retained.
REQ-025 Ages SHALL form a permutation of 0..SET_SIZE-1: on touching way w, ways with age < age[w] increment and w takes 0.
REQ-026 Flush FSM states: IDLE, SCAN, DRAIN, DONE; flush_req&en in IDLE -> SCAN with way pointer 0.
REQ-027 SCAN: valid&dirty way -> DRAIN at word 0; else advance the way; past the last way -> DONE.
REQ-028 DRAIN: wb_valid=1 with wb_tag/wb_index/wb_data stable until wb_valid&wb_ready; each handshake advances the word; the last word clears dirty and returns to SCAN at the next way.
REQ-029 DONE SHALL assert flush_done for exactly one cycle, then return to IDLE.
REQ-030 flush_busy SHALL be 1 in SCAN/DRAIN/DONE; while busy, accesses SHALL update nothing, hit SHALL read 0, and flush_req SHALL be ignored.
REQ-031 en=0 SHALL freeze the FSM; wb outputs SHALL hold.

Reset
REQ-032 Reset SHALL clear valid, dirty and tags, set age[i]=i, and force IDLE; wb_valid, flush_busy, flush_done and hit read 0, and out reads 0.
REQ-033 Data words SHALL not be reset.
REQ-034 Reset mid-walk SHALL abort immediately with no further beats.

Configuration
REQ-035 With CACHE_LFU_EN defined, per-way 8-bit saturating use counters SHALL replace ages: a touch increments, alloc sets 1, the victim is the valid way with the lowest count (lowest index on ties), and reset clears all counters; without the macro, LRU per REQ-025 applies.

Structure
REQ-036 Package cache_pkg SHALL hold the mode enum, the flush state enum and the LFU counter width.
REQ-037 Sub-module cache_way SHALL hold one way (tag, valid, dirty, words, age/counter); assoc_cache_set instantiates SET_SIZE of them.

Verification (SET_SIZE=4, LINE_WIDTH=2)
REQ-038 After reset, req -> victim=0, dirty=0; alloc tag 0x5, then read 0x5 -> hit=1.
REQ-039 Alloc tags A,B,C,D; read A; req -> victim=1 (B); with LFU, touching A twice and B once gives victim C.
REQ-040 Write 0xDEAD to tag A index 2 -> read returns 0xDEAD, dirty set; a write to missing tag E changes nothing.
REQ-041 Two dirty ways with wb_ready toggling -> 8 beats in way/word order, each held until ready, then one flush_done pulse and all dirty bits 0.
REQ-042 Reset asserted during the third DRAIN beat -> wb_valid drops at once, state IDLE, all lines invalid.
